// File: rtl/imm_extend_unit.sv
// imm_extend_unit
//   Registered RISC-V immediate generator (I, S, B, U, J, shamt) for XLEN 32
//   or 64. It has a one-entry valid/ready output stage. Illegal format selects
//   are flagged on the result and counted in a saturating counter.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   instr/imm_src valid this cycle
//   in_ready   unit can accept an input this cycle
//   instr      raw 32-bit instruction word
//   imm_src    format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 shamt,
//              110/111 illegal
//   out_valid  imm_ext/imm_err hold a decoded result
//   out_ready  consumer takes the result this cycle
//   imm_ext    extended immediate, XLEN bits
//   imm_err    result came from an illegal imm_src
//   err_cnt    saturating count of accepted illegal selects
module imm_extend_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic             imm_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_J     = 3'b011;
  localparam logic [2:0] SRC_U     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;

  logic            accept;
  logic            illegal;
  logic [XLEN-1:0] dec;

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // The output slot is free when it is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign illegal  = imm_src[2] && imm_src[1];

  // Each sign-extension replicates instr[31] into every bit above the listed
  // field. The replication count is always at least 1 for XLEN >= 32.
  always_comb begin
    dec = '0;
    case (imm_src)
      SRC_I: dec = {{(XLEN-11){instr[31]}}, instr[30:20]};
      SRC_S: dec = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
      SRC_B: dec = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      SRC_J: dec = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      SRC_U: dec = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
      SRC_SHAMT: begin
        if (XLEN == 64) dec = {{(XLEN-6){1'b0}}, instr[25:20]};
        else            dec = {{(XLEN-5){1'b0}}, instr[24:20]};
      end
      default: dec = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      imm_ext   <= '0;
      imm_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (accept) begin
        // An accept in the same cycle as a release replaces the held result,
        // so out_valid stays high without a bubble.
        out_valid <= 1'b1;
        imm_ext   <= dec;
        imm_err   <= illegal;
        if (illegal && (err_cnt != {CNT_W{1'b1}}))
          err_cnt <= err_cnt + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
